// File: rtl/debounce_filter_array_if.sv
// Sample-side bundle for debounce_filter_array: strobe, mode, raw inputs and
// the filtered level with its edge pulses.
interface debounce_filter_array_if #(
  parameter int unsigned CH = 4
);
  logic          en;
  logic          mode;
  logic [CH-1:0] din;
  logic [CH-1:0] y;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  modport master (output en, mode, din, input y, rise, fall);
  modport slave  (input en, mode, din, output y, rise, fall);
endinterface

// File: rtl/debounce_filter_array.sv
// Per-channel shift-window debouncer with unanimous or majority (tie-hold)
// decision, registered level output and one-cycle rise/fall pulses.
module debounce_filter_array #(
  parameter int unsigned CH    = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  debounce_filter_array_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DepthC = (CW + 1)'(DEPTH);

  logic [DEPTH-1:0] sh_q  [CH];
  logic [DEPTH-1:0] sh_d  [CH];
  logic [CW-1:0]    cnt_q [CH];
  logic [CW-1:0]    cnt_d [CH];
  logic [CH-1:0]    y_q, y_d;
  logic [CH-1:0]    rise_q, rise_d;
  logic [CH-1:0]    fall_q, fall_d;

  always_comb begin
    for (int i = 0; i < int'(CH); i++) begin
      sh_d[i]  = sh_q[i];
      cnt_d[i] = cnt_q[i];
      y_d[i]   = y_q[i];
      if (bus.en) begin
        sh_d[i]  = {sh_q[i][DEPTH-2:0], bus.din[i]};
        // Add incoming and drop outgoing bit in one step; never leaves 0..DEPTH.
        cnt_d[i] = cnt_q[i] + CW'(bus.din[i]) - CW'(sh_q[i][DEPTH-1]);
        if (!bus.mode) begin
          if (&sh_d[i]) begin
            y_d[i] = 1'b1;
          end else if (~|sh_d[i]) begin
            y_d[i] = 1'b0;
          end
        end else begin
          if ({cnt_d[i], 1'b0} > DepthC) begin
            y_d[i] = 1'b1;
          end else if ({cnt_d[i], 1'b0} < DepthC) begin
            y_d[i] = 1'b0;
          end
        end
      end
    end
    rise_d = y_d & ~y_q;
    fall_d = ~y_d & y_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CH); i++) begin
        sh_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      y_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < int'(CH); i++) begin
        sh_q[i]  <= sh_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      y_q    <= y_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
endmodule

// File: tb/tb_debounce_filter_array.sv
// Randomised and directed bench for debounce_filter_array against a
// sample-history reference model.
module tb_debounce_filter_array;
  localparam int CH    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  debounce_filter_array_if #(.CH(CH)) bus ();

  debounce_filter_array #(.CH(CH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: last DEPTH enabled samples per channel, oldest at index 0.
  int            win [CH][DEPTH];
  logic [CH-1:0] exp_y, exp_r, exp_f;

  function automatic void model_edge(input logic r_n, input logic e, input logic m,
                                     input logic [CH-1:0] d);
    int   ones;
    logic nv;
    if (!r_n) begin
      for (int c = 0; c < CH; c++) for (int k = 0; k < DEPTH; k++) win[c][k] = 0;
      exp_y = '0; exp_r = '0; exp_f = '0;
      return;
    end
    exp_r = '0;
    exp_f = '0;
    if (!e) return;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < DEPTH - 1; k++) win[c][k] = win[c][k+1];
      win[c][DEPTH-1] = d[c] ? 1 : 0;
      ones = 0;
      for (int k = 0; k < DEPTH; k++) ones += win[c][k];
      nv = exp_y[c];
      if (!m) begin
        if (ones == DEPTH) nv = 1'b1;
        else if (ones == 0) nv = 1'b0;
      end else begin
        if (2 * ones > DEPTH) nv = 1'b1;
        else if (2 * ones < DEPTH) nv = 1'b0;
      end
      exp_r[c] = nv & ~exp_y[c];
      exp_f[c] = ~nv & exp_y[c];
      exp_y[c] = nv;
    end
  endfunction

  task automatic tick(input logic r_n, input logic e, input logic m, input logic [CH-1:0] d);
    rst_n    = r_n;
    bus.en   = e;
    bus.mode = m;
    bus.din  = d;
    @(posedge clk);
    model_edge(r_n, e, m, d);
    #1;
  endtask

  task automatic test_reset;
    for (int e = 0; e < 3; e++) begin
      tick(1'b0, 1'b1, 1'b0, '1);
      checks++;
      if (bus.y !== 4'b0 || bus.rise !== 4'b0 || bus.fall !== 4'b0) begin
        errors++;
        $display("FAIL reset edge%0d: y=%b rise=%b fall=%b, required all 0",
                 e, bus.y, bus.rise, bus.fall);
      end
    end
    // An all-zero window needs DEPTH ones before y may rise.
    for (int e = 1; e <= DEPTH; e++) begin
      tick(1'b1, 1'b1, 1'b0, 4'b1111);
      checks++;
      if (bus.y !== ((e == DEPTH) ? 4'b1111 : 4'b0000)) begin
        errors++;
        $display("FAIL reset_window edge%0d: y=%b, required %b", e, bus.y,
                 (e == DEPTH) ? 4'b1111 : 4'b0000);
      end
    end
  endtask

  task automatic test_unanimous_rise;
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int e = 1; e <= 6; e++) begin
      tick(1'b1, 1'b1, 1'b0, 4'b0001);
      checks++;
      if (bus.y !== ((e >= 4) ? 4'b0001 : 4'b0000) ||
          bus.rise !== ((e == 4) ? 4'b0001 : 4'b0000) || bus.fall !== 4'b0) begin
        errors++;
        $display("FAIL unanimous_rise edge%0d: y=%b rise=%b fall=%b", e, bus.y, bus.rise,
                 bus.fall);
      end
    end
  endtask

  task automatic test_glitch;
    logic [11:0] seq = 12'b1111_0000_1011; // LSB first: 1,1,0,1,0,0,0,0,1,1,1,1
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int e = 0; e < 12; e++) begin
      tick(1'b1, 1'b1, 1'b0, {3'b0, seq[e]});
      checks++;
      if (bus.y !== ((e == 11) ? 4'b0001 : 4'b0000) ||
          bus.rise !== ((e == 11) ? 4'b0001 : 4'b0000) || bus.fall !== 4'b0) begin
        errors++;
        $display("FAIL glitch edge%0d: y=%b rise=%b fall=%b", e, bus.y, bus.rise, bus.fall);
      end
    end
  endtask

  task automatic test_majority;
    logic [5:0] seq  = 6'b000111;  // LSB first: 1,1,1,0,0,0
    logic [5:0] ye   = 6'b011100;  // y after each edge
    logic [5:0] re   = 6'b000100;
    logic [5:0] fe   = 6'b100000;
    tick(1'b0, 1'b0, 1'b1, '0);
    for (int e = 0; e < 6; e++) begin
      tick(1'b1, 1'b1, 1'b1, {2'b0, seq[e], 1'b0});
      checks++;
      if (bus.y !== {2'b0, ye[e], 1'b0} || bus.rise !== {2'b0, re[e], 1'b0} ||
          bus.fall !== {2'b0, fe[e], 1'b0}) begin
        errors++;
        $display("FAIL majority edge%0d: y=%b rise=%b fall=%b, required y=%b", e, bus.y,
                 bus.rise, bus.fall, {2'b0, ye[e], 1'b0});
      end
    end
  endtask

  task automatic test_en_gating;
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int e = 0; e < 4; e++) tick(1'b1, 1'b1, 1'b0, 4'b0010);
    for (int e = 0; e < 10; e++) begin
      tick(1'b1, 1'b0, e[0], (e % 2 == 0) ? 4'b1101 : 4'b0010);
      checks++;
      if (bus.y !== 4'b0010 || bus.rise !== 4'b0 || bus.fall !== 4'b0) begin
        errors++;
        $display("FAIL en_gating hold%0d: y=%b rise=%b fall=%b, required y=0010",
                 e, bus.y, bus.rise, bus.fall);
      end
    end
    for (int e = 1; e <= 4; e++) begin
      tick(1'b1, 1'b1, 1'b0, 4'b0000);
      checks++;
      if (bus.y !== ((e == 4) ? 4'b0000 : 4'b0010) ||
          bus.fall !== ((e == 4) ? 4'b0010 : 4'b0000) || bus.rise !== 4'b0) begin
        errors++;
        $display("FAIL en_gating resume%0d: y=%b rise=%b fall=%b", e, bus.y, bus.rise,
                 bus.fall);
      end
    end
  endtask

  task automatic test_reset_mid;
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int e = 0; e < 4; e++) tick(1'b1, 1'b1, 1'b1, 4'b1111);
    checks++;
    if (bus.y !== 4'b1111) begin
      errors++;
      $display("FAIL reset_mid setup: y=%b, required 1111", bus.y);
    end
    tick(1'b0, 1'b1, 1'b0, 4'b1111);
    checks++;
    if (bus.y !== 4'b0 || bus.fall !== 4'b0 || bus.rise !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid clear: y=%b rise=%b fall=%b, required 0", bus.y, bus.rise,
               bus.fall);
    end
    for (int e = 1; e <= 4; e++) begin
      tick(1'b1, 1'b1, 1'b0, 4'b1111);
      checks++;
      if (bus.y !== ((e == 4) ? 4'b1111 : 4'b0000) || bus.fall !== 4'b0) begin
        errors++;
        $display("FAIL reset_mid refill%0d: y=%b fall=%b", e, bus.y, bus.fall);
      end
    end
  endtask

  task automatic test_random;
    logic [CH-1:0] d = '0;
    logic          m = 1'b0;
    logic          e;
    logic          r;
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 3) == 0) d[c] = ~d[c];
      if ($urandom_range(0, 15) == 0) m = ~m;
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 99) != 0);
      tick(r, e, m, d);
      checks++;
      if (bus.y !== exp_y || bus.rise !== exp_r || bus.fall !== exp_f) begin
        errors++;
        $display("FAIL random n%0d: y=%b rise=%b fall=%b, required y=%b rise=%b fall=%b",
                 n, bus.y, bus.rise, bus.fall, exp_y, exp_r, exp_f);
      end
      checks++;
      if ((bus.rise & bus.fall) !== 4'b0) begin
        errors++;
        $display("FAIL random_excl n%0d: rise=%b fall=%b overlap", n, bus.rise, bus.fall);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.mode = 1'b0;
    bus.din  = '0;
    exp_y    = '0;
    exp_r    = '0;
    exp_f    = '0;
    test_reset();
    test_unanimous_rise();
    test_glitch();
    test_majority();
    test_en_gating();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/debounce_filter_array.md
DEBOUNCE_FILTER_ARRAY -- requirements
Module: debounce_filter_array

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter DEPTH, default 4: shift-window length per channel, range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 en  input  1  sample strobe; window advances only on edges where en=1.
REQ-006 mode  input  1  0 = unanimous (all-agree), 1 = majority with tie-hold.
REQ-007 din  input  CH  raw per-channel input bits.
REQ-008 y  output  CH  filtered level per channel, registered.
REQ-009 rise  output  CH  one-cycle pulse, registered, when y[i] goes 0->1.
REQ-010 fall  output  CH  one-cycle pulse, registered, when y[i] goes 1->0.

Function
REQ-011 Each channel SHALL hold a DEPTH-bit shift register sh[i] plus a ones-counter cnt[i] of width clog2(DEPTH+1).
REQ-012 On an edge with en=1, sh[i] SHALL become {sh[i][DEPTH-2:0], din[i]}; cnt[i] SHALL add din[i] and subtract the bit shifted out, in one step, with no overflow or underflow.
REQ-013 y[i] SHALL be computed from the new window (post-shift) and registered at the same edge; latency from din sampling to y change is therefore 0 extra cycles after the DEPTH-th agreeing sample.
REQ-014 mode=0: y[i] SHALL become 1 when the new window is all ones, 0 when all zeros, else hold.
REQ-015 mode=1: y[i] SHALL become 1 when 2*cnt > DEPTH, 0 when 2*cnt < DEPTH, hold when 2*cnt = DEPTH (even DEPTH only).
REQ-016 rise[i]/fall[i] SHALL be 1 for exactly the one cycle following the edge at which y[i] changed, else 0; never both 1 for the same channel.
REQ-017 On edges with en=0, sh, cnt and y SHALL hold, and rise/fall SHALL be 0.
REQ-018 A change of mode SHALL take effect at the next en=1 edge, using existing window history; no flush.
REQ-019 Channels SHALL be fully independent; any combination of channels may change on the same edge.
REQ-020 Window history is the only history: for DEPTH consecutive enabled samples of one value, y SHALL equal that value in either mode.

Reset
REQ-021 When rst_n=0 at a rising edge: sh=0, cnt=0, y=0, rise=0, fall=0 for all channels, regardless of en, mode, din.
REQ-022 Reset SHALL take priority over en; reset while y[i]=1 SHALL NOT produce a fall pulse.
REQ-023 After rst_n returns to 1, the first en=1 edge SHALL shift into an all-zero window.

Verification
REQ-024 Reset: din=all ones, en=1, rst_n=0 for 3 edges -> y=0, rise=fall=0 throughout; cnt=0.
REQ-025 Mode 0, DEPTH=4, en=1: din[0]=1 from edge 1 -> y[0]=1 after edge 4, rise[0]=1 for exactly that one cycle; other channels stay 0.
REQ-026 Mode 0 glitch: din[0] sequence 1,1,0,1,0,0,0,0 -> y[0] stays 0, no rise/fall; then 1 for 4 edges -> y[0]=1.
REQ-027 Mode 1, DEPTH=4: window 1110 -> y=1; next sample 0 gives 1100 (tie) -> y holds 1; next 0 gives 1000 -> y=0 with one fall pulse.
REQ-028 en gating: y[1]=1, en=0 for 10 edges while din[1] toggles every edge -> y, sh unchanged, rise=fall=0; resuming en continues from prior window.
REQ-029 Reset mid-operation: all y=1, rst_n=0 for one edge -> y=0, fall=0; subsequent 3 enabled ones with DEPTH=4 -> y still 0, 4th -> y=1.
